// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: match flow FSM with HP tracking, winner decision and layer ObjectID decode
module game_flow_ctrl #(
  parameter int MAX_HP       = 100,
  parameter int HIT_DMG      = 10,
  parameter int START_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       p1_shield,
  input  logic       p2_shield,
  output logic [1:0] state,
  output logic [6:0] p1_hp,
  output logic [6:0] p2_hp,
  output logic [3:0] bg_obj,
  output logic [3:0] caption_obj,
  output logic       caption_valid,
  output logic       play_en,
  output logic [1:0] winner
);
  typedef enum logic [1:0] {IDLE, START, PLAY, OVER} state_t;
  localparam logic [6:0] MHP = 7'(MAX_HP);
  localparam logic [6:0] DMG = 7'(HIT_DMG);
  localparam logic [7:0] SF  = 8'(START_FRAMES);
  localparam logic [7:0] OF  = 8'(OVER_FRAMES);
  state_t st, st_n;
  logic [7:0] cnt, cnt_n, cnt_inc, cnt_tk;
  logic [6:0] d1, d2, h1_n, h2_n;
  logic [1:0] win_n;
  // next HP, saturating counter and next-state selection
  always_comb begin
    d1 = (p1_hit & ~p1_shield) ? (p1_hp > DMG ? p1_hp - DMG : 7'd0) : p1_hp;
    d2 = (p2_hit & ~p2_shield) ? (p2_hp > DMG ? p2_hp - DMG : 7'd0) : p2_hp;
    cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;
    cnt_tk = frame_tick ? cnt_inc : cnt;
    st_n = st;
    cnt_n = cnt;
    win_n = winner;
    h1_n = p1_hp;
    h2_n = p2_hp;
    case (st)
      IDLE: if (start_btn) begin
        st_n = START;
        cnt_n = 8'd0;
        win_n = 2'b00;
        h1_n = MHP;
        h2_n = MHP;
      end
      START: if (frame_tick && cnt_inc == SF) begin
        st_n = PLAY;
        cnt_n = 8'd0;
      end else cnt_n = cnt_tk;
      PLAY: begin
        h1_n = d1;
        h2_n = d2;
        if (d1 == 7'd0 || d2 == 7'd0) begin
          st_n = OVER;
          cnt_n = 8'd0;
          win_n = {d1 == 7'd0, d2 == 7'd0};
        end
      end
      default: if (cnt >= OF && start_btn) st_n = IDLE;
      else cnt_n = cnt_tk;
    endcase
  end
  // state, counter, winner and HP registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= 8'd0;
      winner <= 2'b00;
      p1_hp <= MHP;
      p2_hp <= MHP;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      winner <= win_n;
      p1_hp <= h1_n;
      p2_hp <= h2_n;
    end
  end
  // layer decode straight from the registered state
  always_comb begin
    state = st;
    play_en = st == PLAY;
    caption_valid = st == START || st == OVER;
    bg_obj = st == IDLE ? 4'd11 : st == START ? 4'd13 : 4'd0;
    caption_obj = st == START ? 4'd12 :
                  st != OVER ? 4'd0 :
                  winner == 2'b01 ? 4'd9 : winner[1] ? 4'd10 : 4'd0;
  end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter MAX_HP, default 100: HP loaded into each player at match start.
REQ-002 Parameter HIT_DMG, default 10: HP removed per accepted hit.
REQ-003 Parameter START_FRAMES, default 60: frames the start caption is shown (1..255).
REQ-004 Parameter OVER_FRAMES, default 180: frames the win/lose caption is held before restart is allowed (1..255).
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 start_btn  in  1  level; sampled every cycle.
REQ-009 p1_hit, p2_hit  in  1 each  one-cycle pulse: bullet struck player 1 / player 2.
REQ-010 p1_shield, p2_shield  in  1 each  level: player's shield is up.
REQ-011 state  out  2  00 IDLE, 01 START, 10 PLAY, 11 OVER.
REQ-012 p1_hp, p2_hp  out  7 each  current HP, unsigned.
REQ-013 bg_obj  out  4  ObjectID of the background layer.
REQ-014 caption_obj  out  4  ObjectID of the caption layer; caption_valid  out  1  caption layer shown.
REQ-015 play_en  out  1  high only in PLAY; enables motion, jump and bullet logic.
REQ-016 winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-017 The FSM SHALL have states IDLE, START, PLAY and OVER, each registered.
REQ-018 IDLE SHALL go to START on the first cycle start_btn is high.
REQ-019 On entry to START, the block SHALL load p1_hp and p2_hp with MAX_HP, clear winner to 00, and clear the frame counter.
REQ-020 In START and OVER, the 8-bit frame counter SHALL increment on each frame_tick and SHALL saturate at 255.
REQ-021 START SHALL go to PLAY on the frame_tick that makes the counter equal START_FRAMES.
REQ-022 In PLAY, a pxN_hit SHALL be accepted only when the matching pxN_shield is low; hits in any other state SHALL be ignored.
REQ-023 An accepted hit SHALL reduce that player's HP by HIT_DMG on the next edge, saturating at 0 (no wrap-around).
REQ-024 Simultaneous accepted hits on both players SHALL both be applied in the same cycle.
REQ-025 The next-HP value SHALL be computed combinationally. On the edge where a player's next HP is 0, the FSM SHALL enter OVER, and winner SHALL be set as follows:
- 01 if only p2 reaches 0;
- 10 if only p1 reaches 0;
- 11 if both reach 0.
REQ-026 On entry to OVER, the frame counter SHALL be cleared, and HP SHALL be frozen.
REQ-027 OVER SHALL go to IDLE when the counter is at least OVER_FRAMES and start_btn is high. start_btn SHALL be ignored before that point.
REQ-028 bg_obj SHALL be:
- 11 (IDLE_BG) in IDLE;
- 13 (START_BG) in START;
- 0 (MAP) in PLAY and OVER.
REQ-029 caption_valid SHALL be 1 in START and OVER and 0 otherwise. caption_obj SHALL be:
- 12 (START_CAPTION) in START;
- 9 (WIN_CAPTION) in OVER when winner is 01;
- 10 (LOSE_CAPTION) in OVER when winner is 10 or 11;
- 0 otherwise.
REQ-030 bg_obj, caption_obj, caption_valid and play_en SHALL be decoded from the registered state, with zero added latency relative to state.
REQ-031 A frame_tick coincident with a state transition SHALL NOT count toward the new state's counter.

Reset
REQ-032 While rst is high, the block SHALL hold:
- state=IDLE, counter=0, winner=00;
- p1_hp=p2_hp=MAX_HP;
- bg_obj=11, caption_obj=0, caption_valid=0, play_en=0.
REQ-033 Reset asserted mid-match SHALL return the block to IDLE immediately, asynchronously, with no HP update applied.
REQ-034 After rst deasserts, the FSM SHALL take no action until start_btn is seen.

Verification
REQ-035 Reset release, start_btn high for 1 cycle, 60 frame_ticks -> state goes IDLE -> START -> PLAY on the 60th tick; bg_obj goes 11 -> 13 -> 0; play_en rises with PLAY.
REQ-036 In PLAY, 10 p2_hit pulses with p2_shield=0 -> p2_hp steps 90, 80 ... 0; on the 10th hit state=OVER, winner=01, caption_obj=9.
REQ-037 In PLAY, p1_hit with p1_shield=1 -> p1_hp stays 100; a hit pulse in START or OVER -> no HP change.
REQ-038 With HIT_DMG=30, p1_hp=100 and four hits -> p1_hp is 70, 40, 10, then 0 (saturated); winner=10; caption_obj=10.
REQ-039 Both players at 10 HP with same-cycle p1_hit and p2_hit -> both HP 0, winner=11, caption_obj=10.
REQ-040 In OVER, start_btn at tick 100 -> ignored; start_btn after tick 180 -> IDLE. Separately, rst asserted mid-PLAY -> immediate IDLE with HP=100.
